// File: rtl/reg_file_wb.sv
// reg_file_wb: 2^ADDR_W x WIDTH write-back register file, r0 hard-wired to zero.
// Define RF_BYPASS_EN for same-cycle write-through forwarding on both read ports.
module reg_file_wb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);

    localparam int NREG = 1 << ADDR_W;

    // Entry 0 has no storage; the read mux falls back to zero for it.
    logic [WIDTH-1:0] mem [1:NREG-1];
    logic [WIDTH-1:0] st1;
    logic [WIDTH-1:0] st2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (WE && (WA == ADDR_W'(i))) begin
                    mem[i] <= WD;
                end
            end
        end
    end

    always_comb begin
        st1 = '0;
        st2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (RA1 == ADDR_W'(i)) begin
                st1 = mem[i];
            end
            if (RA2 == ADDR_W'(i)) begin
                st2 = mem[i];
            end
        end
    end

`ifdef RF_BYPASS_EN
    // Forwarding is suppressed in reset so outputs stay zero.
    logic wr_act;

    assign wr_act = rst_n && WE && (WA != '0);
    assign RD1    = (wr_act && (RA1 == WA)) ? WD : st1;
    assign RD2    = (wr_act && (RA2 == WA)) ? WD : st2;
`else
    assign RD1 = st1;
    assign RD2 = st2;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: vector table, directed corner sequences and random
// traffic against an array model of the register file.
module tb_reg_file_wb;

    logic        clk;
    logic        rst_n;
    logic        WE;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks;
    int failures;

    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [6];

    reg_file_wb #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .WE(WE),
        .WA(WA),
        .WD(WD),
        .RA1(RA1),
        .RA2(RA2),
        .RD1(RD1),
        .RD2(RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1;
        WA = a;
        WD = d;
        tick();
        WE = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'h0 : model[ra];
`ifdef RF_BYPASS_EN
        if (WE && WA != 5'd0 && ra == WA) v = WD;
`endif
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        WE    = 1'b0;
        WA    = '0;
        WD    = '0;
        RA1   = 5'd5;
        RA2   = 5'd31;
        rst_n = 1'b0;

        // Reset state
        #12;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_rd1", RD1, 32'h0);
        check("idle_rd2", RD2, 32'h0);

        // Vector table: drive, take one edge, check reads after it
        vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7,
                    32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd8, 5'd7, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7,
                    32'h0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd3, 32'h1234, 5'd3, 5'd0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd4, 32'h11, 5'd4, 5'd3, 32'h11, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hA5A5_5A5A, 5'd31, 5'd4,
                    32'hA5A5_5A5A, 32'h11};
        for (int i = 0; i < 6; i++) begin
            WE  = vecs[i].we;
            WA  = vecs[i].wa;
            WD  = vecs[i].wd;
            RA1 = vecs[i].ra1;
            RA2 = vecs[i].ra2;
            tick();
            WE = 1'b0;
            #1;
            check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e2);
            if (vecs[i].we && vecs[i].wa != 5'd0)
                model[vecs[i].wa] = vecs[i].wd;
        end

        // Read during write on r4 (holds 0x11)
        WE  = 1'b1;
        WA  = 5'd4;
        WD  = 32'h22;
        RA1 = 5'd4;
        #1;
`ifdef RF_BYPASS_EN
        check("rdw_before", RD1, 32'h22);
`else
        check("rdw_before", RD1, 32'h11);
`endif
        tick();
        WE = 1'b0;
        model[4] = 32'h22;
        #1;
        check("rdw_after", RD1, 32'h22);

        // Async reset mid-operation
        for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
        RA1 = 5'd5;
        RA2 = 5'd31;
        #1;
        check("fill_rd1", RD1, 32'd5);
        check("fill_rd2", RD2, 32'd31);
        @(negedge clk);
        #1;
        WE    = 1'b1;
        WA    = 5'd9;
        WD    = 32'hABCD;
        RA1   = 5'd9;
        rst_n = 1'b0;
        #1;
        check("async_rd1", RD1, 32'h0);
        check("async_rd2", RD2, 32'h0);
        @(posedge clk);
        #1;
        check("rst_write_blocked", RD1, 32'h0);
        @(negedge clk);
        WE    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(31 - i);
            #1;
            check($sformatf("clr_rd1_r%0d", i), RD1, 32'h0);
            check($sformatf("clr_rd2_r%0d", 31 - i), RD2, 32'h0);
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            WE  = 1'($urandom_range(0, 1));
            WA  = 5'($urandom_range(0, 31));
            WD  = $urandom;
            RA1 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
            RA2 = 5'($urandom_range(0, 31));
            #1;
            check("rand_rd1", RD1, expect_rd(RA1));
            check("rand_rd2", RD2, expect_rd(RA2));
            tick();
            if (WE && WA != 5'd0) model[WA] = WD;
        end
        WE = 1'b0;

        // Full sweep, both ports
        for (int i = 1; i < 32; i++) write(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(i);
            #1;
            check($sformatf("sweep_rd1_r%0d", i), RD1,
                  32'(i) * 32'h01010101);
            check($sformatf("sweep_rd2_r%0d", i), RD2,
                  32'(i) * 32'h01010101);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
